// File: rtl/clint_int_gen.sv
// Core-local interrupt generator: mtime/mtimecmp timer, msip, synchronised external request.
// Define CLINT_DEBUG_REQ_EN to add the debug_req_in path; otherwise debug_int is tied to 0.
module clint_int_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  bus_addr,
  input  logic        bus_wen,
  input  logic        bus_ren,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        bus_err,
  input  logic        ext_irq_in,
`ifdef CLINT_DEBUG_REQ_EN
  input  logic        debug_req_in,
`endif
  output logic [63:0] mtime,
  output logic        timer_int,
  output logic        soft_int,
  output logic        ext_int,
  output logic        debug_int,
  input  logic        timer_int_clear,
  input  logic        soft_int_clear,
  input  logic        ext_int_clear,
  input  logic        debug_int_clear
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [2:0]  widx;
  logic        mapped;
  logic        rd_acc;
  logic        wr_msip, wr_cmp_lo, wr_cmp_hi, wr_time_lo, wr_time_hi;
  logic [15:0] presc;
  logic        tick;
  logic [63:0] mtimecmp;
  logic        cmp_hit;
  logic        timer_ack, timer_ack_nxt;
  logic [31:0] rdata_mux;
  logic [2:0]  ext_sh;
  logic        ext_edge;
  logic        unused_bits;

  assign widx       = bus_addr[4:2];
  assign mapped     = (widx <= 3'd4);
  assign rd_acc     = bus_ren & ~bus_wen;
  assign wr_msip    = bus_wen & (widx == 3'd0);
  assign wr_cmp_lo  = bus_wen & (widx == 3'd1);
  assign wr_cmp_hi  = bus_wen & (widx == 3'd2);
  assign wr_time_lo = bus_wen & (widx == 3'd3);
  assign wr_time_hi = bus_wen & (widx == 3'd4);
  assign unused_bits = ^bus_addr[1:0];

  assign tick = (presc == PRESC_MAX);

  // A bus write to either mtime half pre-empts the increment and restarts the prescaler.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mtime <= 64'd0;
      presc <= 16'd0;
    end else if (wr_time_lo || wr_time_hi) begin
      presc <= 16'd0;
      if (wr_time_lo) mtime[31:0]  <= bus_wdata;
      if (wr_time_hi) mtime[63:32] <= bus_wdata;
    end else if (tick) begin
      presc <= 16'd0;
      mtime <= mtime + 64'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mtimecmp <= '1;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= bus_wdata;
      if (wr_cmp_hi) mtimecmp[63:32] <= bus_wdata;
    end
  end

  assign cmp_hit = (mtime >= mtimecmp);

  always_comb begin
    timer_ack_nxt = timer_ack;
    if (wr_cmp_lo || wr_cmp_hi) timer_ack_nxt = 1'b0;
    else if (timer_int_clear)   timer_ack_nxt = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_ack <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      timer_ack <= timer_ack_nxt;
      timer_int <= cmp_hit & ~timer_ack_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                 soft_int <= 1'b0;
    else if (wr_msip)        soft_int <= bus_wdata[0];
    else if (soft_int_clear) soft_int <= 1'b0;
  end

  // Two synchroniser stages plus a history flop for rising-edge detection.
  assign ext_edge = ext_sh[1] & ~ext_sh[2];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ext_sh  <= 3'b000;
      ext_int <= 1'b0;
    end else begin
      ext_sh <= {ext_sh[1:0], ext_irq_in};
      if (ext_edge)           ext_int <= 1'b1;
      else if (ext_int_clear) ext_int <= 1'b0;
    end
  end

`ifdef CLINT_DEBUG_REQ_EN
  logic [2:0] dbg_sh;
  logic       dbg_edge;

  assign dbg_edge = dbg_sh[1] & ~dbg_sh[2];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dbg_sh    <= 3'b000;
      debug_int <= 1'b0;
    end else begin
      dbg_sh <= {dbg_sh[1:0], debug_req_in};
      if (dbg_edge)             debug_int <= 1'b1;
      else if (debug_int_clear) debug_int <= 1'b0;
    end
  end
`else
  logic unused_dbg;
  assign unused_dbg = debug_int_clear;
  assign debug_int  = 1'b0;
`endif

  always_comb begin
    rdata_mux = 32'd0;
    case (widx)
      3'd0:    rdata_mux = {31'd0, soft_int};
      3'd1:    rdata_mux = mtimecmp[31:0];
      3'd2:    rdata_mux = mtimecmp[63:32];
      3'd3:    rdata_mux = mtime[31:0];
      3'd4:    rdata_mux = mtime[63:32];
      default: rdata_mux = 32'd0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus_rdata  <= 32'd0;
      bus_rvalid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      bus_rvalid <= rd_acc;
      bus_err    <= (bus_wen | bus_ren) & ~mapped;
      bus_rdata  <= rd_acc ? rdata_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_clint_int_gen.sv
// Bench for clint_int_gen: PRESCALE=1 and PRESCALE=4 instances on a shared bus,
// read responses checked against a queue of expected values.
module tb_clint_int_gen;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [4:0]  bus_addr = '0;
  logic        bus_wen = 1'b0;
  logic        bus_ren = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic        ext_irq_in = 1'b0;
  logic        timer_int_clear = 1'b0;
  logic        soft_int_clear = 1'b0;
  logic        ext_int_clear = 1'b0;
  logic        debug_int_clear = 1'b0;
`ifdef CLINT_DEBUG_REQ_EN
  logic        debug_req_in = 1'b0;
`endif

  logic [31:0] rdata, rdata4;
  logic        rvalid, rvalid4, err, err4;
  logic [63:0] mtime, mtime4;
  logic        timer_int, soft_int, ext_int, debug_int;
  logic        timer_int4, soft_int4, ext_int4, debug_int4;

  typedef struct {
    logic        care;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  clint_int_gen #(.PRESCALE(1)) u_dut (
    .CLK(CLK), .RST(RST), .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren),
    .bus_wdata(bus_wdata), .bus_rdata(rdata), .bus_rvalid(rvalid), .bus_err(err),
    .ext_irq_in(ext_irq_in),
`ifdef CLINT_DEBUG_REQ_EN
    .debug_req_in(debug_req_in),
`endif
    .mtime(mtime), .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
    .debug_int(debug_int), .timer_int_clear(timer_int_clear), .soft_int_clear(soft_int_clear),
    .ext_int_clear(ext_int_clear), .debug_int_clear(debug_int_clear)
  );

  clint_int_gen #(.PRESCALE(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren),
    .bus_wdata(bus_wdata), .bus_rdata(rdata4), .bus_rvalid(rvalid4), .bus_err(err4),
    .ext_irq_in(ext_irq_in),
`ifdef CLINT_DEBUG_REQ_EN
    .debug_req_in(debug_req_in),
`endif
    .mtime(mtime4), .timer_int(timer_int4), .soft_int(soft_int4), .ext_int(ext_int4),
    .debug_int(debug_int4), .timer_int_clear(timer_int_clear), .soft_int_clear(soft_int_clear),
    .ext_int_clear(ext_int_clear), .debug_int_clear(debug_int_clear)
  );

  // Read-response monitors
  always @(negedge CLK) begin
    if (!RST && rvalid) begin
      exp_t e;
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected got rvalid=1 rdata=%h required no response", rdata);
      end else begin
        e = q1.pop_front();
        if (rdata !== e.data || err !== e.err) begin
          errors++;
          $display("FAIL rd_resp got %h err=%b required %h err=%b", rdata, err, e.data, e.err);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST && rvalid4) begin
      exp_t e;
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid4_unexpected got rvalid=1 rdata=%h required no response", rdata4);
      end else begin
        e = q4.pop_front();
        if (e.care) begin
          checks++;
          if (rdata4 !== e.data || err4 !== e.err) begin
            errors++;
            $display("FAIL rd_resp4 got %h err=%b required %h err=%b", rdata4, err4, e.data, e.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
    cyc();
    bus_wen = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp1, input logic exp_err,
                    input logic care4, input logic [31:0] exp4);
    q1.push_back('{1'b1, exp1, exp_err});
    q4.push_back('{care4, exp4, exp_err});
    bus_addr = a; bus_ren = 1'b1;
    cyc();
    bus_ren = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    checks++;
    if ({timer_int, soft_int, ext_int, debug_int, rvalid, err} !== 6'b0 || rdata !== 32'd0 ||
        mtime !== 64'd0 || mtime4 !== 64'd0 || soft_int4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ints=%b%b%b%b rv=%b err=%b rdata=%h mtime=%h required all 0",
               timer_int, soft_int, ext_int, debug_int, rvalid, err, rdata, mtime);
    end
    RST = 1'b0;
  endtask

  task automatic test_prescale();
    repeat (11) cyc();
    checks++;
    if (mtime4 !== 64'd2 || mtime !== 64'd11) begin
      errors++;
      $display("FAIL presc_cycle11 got mtime4=%0d mtime=%0d required 2 11", mtime4, mtime);
    end
    cyc();
    checks++;
    if (mtime4 !== 64'd3 || mtime !== 64'd12) begin
      errors++;
      $display("FAIL presc_cycle12 got mtime4=%0d mtime=%0d required 3 12", mtime4, mtime);
    end
    rd(5'h04, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF);
    wr(5'h0C, 32'd100);
    rd(5'h0C, 32'd100, 1'b0, 1'b1, 32'd100);
    cyc(); cyc();
    checks++;
    if (mtime4 !== 64'd100) begin
      errors++;
      $display("FAIL presc_hold got mtime4=%0d required 100", mtime4);
    end
    cyc();
    checks++;
    if (mtime4 !== 64'd101) begin
      errors++;
      $display("FAIL presc_incr got mtime4=%0d required 101", mtime4);
    end
  endtask

  task automatic test_timer();
    wr(5'h10, 32'd0);
    wr(5'h0C, 32'd0);
    wr(5'h08, 32'd0);
    wr(5'h04, 32'd10);
    repeat (8) cyc();
    checks++;
    if (mtime !== 64'd10 || timer_int !== 1'b0) begin
      errors++;
      $display("FAIL timer_before got mtime=%0d timer_int=%b required 10 0", mtime, timer_int);
    end
    cyc();
    checks++;
    if (timer_int !== 1'b1) begin
      errors++;
      $display("FAIL timer_rise got %b required 1", timer_int);
    end
    timer_int_clear = 1'b1;
    cyc();
    timer_int_clear = 1'b0;
    checks++;
    if (timer_int !== 1'b0) begin
      errors++;
      $display("FAIL timer_clear got %b required 0", timer_int);
    end
    cyc();
    checks++;
    if (timer_int !== 1'b0) begin
      errors++;
      $display("FAIL timer_ack_hold got %b required 0", timer_int);
    end
    wr(5'h04, 32'd5);
    cyc();
    checks++;
    if (timer_int !== 1'b1) begin
      errors++;
      $display("FAIL timer_rearm got %b required 1", timer_int);
    end
    wr(5'h08, 32'd1);
    cyc();
    checks++;
    if (timer_int !== 1'b0) begin
      errors++;
      $display("FAIL timer_cmp_raise got %b required 0", timer_int);
    end
  endtask

  task automatic test_soft();
    wr(5'h00, 32'd1);
    checks++;
    if (soft_int !== 1'b1) begin
      errors++;
      $display("FAIL soft_set got %b required 1", soft_int);
    end
    bus_addr = 5'h00; bus_wdata = 32'd1; bus_wen = 1'b1; soft_int_clear = 1'b1;
    cyc();
    bus_wen = 1'b0; soft_int_clear = 1'b0;
    checks++;
    if (soft_int !== 1'b1) begin
      errors++;
      $display("FAIL soft_write_wins got %b required 1", soft_int);
    end
    soft_int_clear = 1'b1;
    cyc();
    soft_int_clear = 1'b0;
    checks++;
    if (soft_int !== 1'b0) begin
      errors++;
      $display("FAIL soft_clear got %b required 0", soft_int);
    end
    wr(5'h00, 32'hFFFF_FFFF);
    rd(5'h00, 32'd1, 1'b0, 1'b1, 32'd1);
    wr(5'h00, 32'd0);
    checks++;
    if (soft_int !== 1'b0) begin
      errors++;
      $display("FAIL soft_write0 got %b required 0", soft_int);
    end
  endtask

  task automatic test_ext();
    ext_irq_in = 1'b1;
    cyc(); cyc();
    checks++;
    if (ext_int !== 1'b0) begin
      errors++;
      $display("FAIL ext_early got %b required 0", ext_int);
    end
    cyc();
    checks++;
    if (ext_int !== 1'b1) begin
      errors++;
      $display("FAIL ext_rise got %b required 1", ext_int);
    end
    repeat (16) cyc();
    ext_int_clear = 1'b1;
    cyc();
    ext_int_clear = 1'b0;
    repeat (5) cyc();
    checks++;
    if (ext_int !== 1'b0) begin
      errors++;
      $display("FAIL ext_single_set got %b required 0", ext_int);
    end
    ext_irq_in = 1'b0;
    repeat (3) cyc();
    ext_irq_in = 1'b1;
    repeat (3) cyc();
    ext_irq_in = 1'b0;
    repeat (3) cyc();
    ext_irq_in = 1'b1;
    cyc(); cyc();
    ext_int_clear = 1'b1;
    cyc();
    ext_int_clear = 1'b0;
    checks++;
    if (ext_int !== 1'b1) begin
      errors++;
      $display("FAIL ext_edge_wins got %b required 1", ext_int);
    end
    ext_int_clear = 1'b1;
    cyc();
    ext_int_clear = 1'b0;
    checks++;
    if (ext_int !== 1'b0) begin
      errors++;
      $display("FAIL ext_clear got %b required 0", ext_int);
    end
    ext_irq_in = 1'b0;
  endtask

  task automatic test_debug();
`ifdef CLINT_DEBUG_REQ_EN
    debug_req_in = 1'b1;
    repeat (3) cyc();
    checks++;
    if (debug_int !== 1'b1) begin
      errors++;
      $display("FAIL dbg_rise got %b required 1", debug_int);
    end
    debug_int_clear = 1'b1;
    cyc();
    debug_int_clear = 1'b0;
    debug_req_in = 1'b0;
    checks++;
    if (debug_int !== 1'b0) begin
      errors++;
      $display("FAIL dbg_clear got %b required 0", debug_int);
    end
`else
    ext_irq_in = 1'b1;
    debug_int_clear = 1'b1;
    repeat (4) cyc();
    debug_int_clear = 1'b0;
    checks++;
    if (debug_int !== 1'b0 || debug_int4 !== 1'b0) begin
      errors++;
      $display("FAIL dbg_tied got %b required 0", debug_int);
    end
    ext_int_clear = 1'b1;
    cyc();
    ext_int_clear = 1'b0;
    ext_irq_in = 1'b0;
`endif
  endtask

  task automatic test_bus();
    rd(5'h18, 32'd0, 1'b1, 1'b1, 32'd0);
    wr(5'h1C, 32'hDEAD_BEEF);
    checks++;
    if (err !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_wr got err=%b rvalid=%b required 1 0", err, rvalid);
    end
    cyc();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse got %b required 0", err);
    end
    wr(5'h10, 32'd1);
    wr(5'h0C, 32'd5);
    rd(5'h10, 32'd1, 1'b0, 1'b1, 32'd1);
    rd(5'h0C, 32'd6, 1'b0, 1'b1, 32'd5);
    bus_addr = 5'h00; bus_wdata = 32'd1; bus_wen = 1'b1; bus_ren = 1'b1;
    cyc();
    bus_wen = 1'b0; bus_ren = 1'b0;
    checks++;
    if (soft_int !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_both got soft=%b rvalid=%b required 1 0", soft_int, rvalid);
    end
    soft_int_clear = 1'b1;
    cyc();
    soft_int_clear = 1'b0;
  endtask

  task automatic test_wrap_reset();
    wr(5'h08, 32'hFFFF_FFFF);
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h10, 32'hFFFF_FFFF);
    wr(5'h0C, 32'hFFFF_FFFE);
    checks++;
    if (mtime !== 64'hFFFF_FFFF_FFFF_FFFE || timer_int !== 1'b0) begin
      errors++;
      $display("FAIL wrap_load got mtime=%h timer=%b required fffffffffffffffe 0", mtime, timer_int);
    end
    cyc(); cyc();
    checks++;
    if (mtime !== 64'd0 || timer_int !== 1'b1) begin
      errors++;
      $display("FAIL wrap_hit got mtime=%h timer=%b required 0 1", mtime, timer_int);
    end
    cyc();
    checks++;
    if (mtime !== 64'd1 || timer_int !== 1'b0) begin
      errors++;
      $display("FAIL wrap_after got mtime=%h timer=%b required 1 0", mtime, timer_int);
    end
    wr(5'h04, 32'h0000_1234);
    wr(5'h00, 32'd1);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    checks++;
    if ({timer_int, soft_int, ext_int, debug_int, rvalid, err} !== 6'b0 || rdata !== 32'd0 ||
        mtime !== 64'd0 || mtime4 !== 64'd0) begin
      errors++;
      $display("FAIL async_reset got ints=%b%b%b%b rv=%b err=%b mtime=%h required all 0",
               timer_int, soft_int, ext_int, debug_int, rvalid, err, mtime);
    end
    cyc();
    RST = 1'b0;
    rd(5'h04, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF);
    rd(5'h08, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF);
    cyc();
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_timer();
    test_soft();
    test_ext();
    test_debug();
    test_bus();
    test_wrap_reset();
    cyc();
    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL missing_responses got pending=%0d/%0d required 0/0", q1.size(), q4.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
